aes_op_scheduler: RTL and testbench
===================================

# aes_op_scheduler

Multi-slot operation scheduler for the masked 32-bit AES top level. It arbitrates data runs, PRNG reseeds, key fetches and last-round-key computations into a single serialised sequence. It generalises single-key stream handling to NSLOT key slots, replaces the implicit reseed/rekey gating with a deadlock-free fixed priority, and can force a reseed after a programmable number of encryptions. It sits between the SVRS input streams and the key holder, PRNG and AES core control pins.

## Interface
- NSLOT, 4, number of key slots (≥1)
- SLOT_W, $clog2(NSLOT) (min 1), slot index width
- RESEED_PERIOD, 1024, encryptions allowed between reseeds (≥1); used only with AUTO_RESEED_EN
- CNT_W, 16, encryption counter width; must hold RESEED_PERIOD
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data_valid / in_data_ready  in/out  1/1  plaintext stream handshake
- in_data_slot  in  SLOT_W  key slot for this plaintext, valid with in_data_valid
- in_seed_valid / in_seed_ready  in/out  1/1  seed stream; ready is a 1-cycle consumption pulse
- in_key_valid  in  1  key load request pending
- in_key_slot  in  SLOT_W  target slot of key load
- ksu_busy, core_busy, prng_busy  in  1  busy flags of key holder, AES core, PRNG
- prng_out_valid  in  1  PRNG output usable
- core_in_ready  in  1  AES core accepts a start
- ksu_last_key_req  in  1  key holder requests last-key computation
- core_valid_in  out  1  start AES core
- core_key_schedule_only  out  1  current start is a last-key computation
- core_slot  out  SLOT_W  registered slot of the running operation
- ksu_start_fetch  out  1  start key fetch into core_slot
- prng_start_reseed  out  1  start PRNG reseed
- slot_loaded  out  NSLOT  per-slot key-present flags
- err_no_key  out  1  1-cycle pulse: plaintext dropped, slot not loaded
- reseed_required  out  1  encryption budget exhausted

## Operation
- FSM states: IDLE, RUN, LASTKEY, RESEED, REKEY. A busy_seen flag, cleared on each state entry, records that the relevant busy input has been observed at 1.
- IDLE priority, evaluated each cycle:
  1. ksu_last_key_req & prng_out_valid: core_valid_in=1, core_key_schedule_only=1; on core_in_ready go to LASTKEY.
  2. in_data_valid & prng_out_valid & ~reseed_required:
     - slot_loaded[in_data_slot]=1: core_valid_in=1; in_data_ready=core_in_ready; on handshake latch core_slot, increment counter, go to RUN.
     - slot not loaded: in_data_ready=1, err_no_key pulse, stay IDLE.
  3. in_seed_valid: prng_start_reseed=1, go to RESEED.
  4. in_key_valid: ksu_start_fetch=1, latch core_slot=in_key_slot, go to REKEY.
- RUN / LASTKEY / REKEY / RESEED: wait for busy_seen and then the watched busy input (core_busy / core_busy / ksu_busy / prng_busy) at 0; return to IDLE.
- REKEY exit sets slot_loaded[core_slot]. A REKEY entry clears that bit immediately.
- in_seed_ready = state==RESEED & prng_busy & ~busy_seen, giving exactly one pulse per reseed.
- All start outputs and in_data_ready are 0 outside IDLE.
- Counter saturates at RESEED_PERIOD. reseed_required = (count == RESEED_PERIOD). RESEED exit clears the count to 0.
- Out-of-range slot (≥NSLOT) is treated as unloaded.

## Timing
- Reset: state IDLE, count 0, slot_loaded 0, core_slot 0, busy_seen 0. All outputs 0 except combinational in_data_ready, which is also 0 in IDLE with no request.
- Starts are combinational from IDLE decision; the state change and core_slot are visible the next cycle.
- Minimum op duration is 2 cycles (entry, then busy observed low after seen).
- Busy that never rises holds the FSM indefinitely; no timeout.
- Simultaneous data+seed+key with reseed_required: seed wins, then data is served after reseed.
- Reset mid-operation aborts immediately; slot keys are treated as lost.

## Configuration
- AUTO_RESEED_EN defined: counter, reseed_required and forced reseed as above.
- AUTO_RESEED_EN undefined: no counter, reseed_required tied 0, data never blocked by budget.

## Test plan
- NSLOT=4: key to slot 2 (ksu_busy high 5 cycles) -> slot_loaded=4'b0100 one cycle after ksu_busy falls; data slot 2 -> core_valid_in, core_slot=2.
- Data to slot 1 unloaded -> in_data_ready=1, err_no_key single pulse, no core_valid_in.
- in_seed_valid & in_key_valid together in IDLE -> prng_start_reseed first, in_seed_ready one pulse, then ksu_start_fetch after prng_busy falls.
- AUTO_RESEED_EN, RESEED_PERIOD=3: 3 encryptions accepted, 4th stalls with reseed_required=1; after reseed, 4th accepted, count=1.
- ksu_last_key_req and in_data_valid together -> core_key_schedule_only=1 launch first, data held until LASTKEY completes.
- rst_n low during RUN -> next edge-independent return to IDLE, slot_loaded=0, outputs 0.

Source files
------------

// File: rtl/aes_op_scheduler.sv
// Serialises data runs, PRNG reseeds, key fetches and last-key computations for the masked AES core.
// Optional: define AUTO_RESEED_EN to force a reseed after RESEED_PERIOD encryptions.
module aes_op_scheduler #(
    parameter int NSLOT         = 4,
    parameter int SLOT_W        = (NSLOT > 1) ? $clog2(NSLOT) : 1,
    parameter int RESEED_PERIOD = 1024,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_data_valid,
    output logic              in_data_ready,
    input  logic [SLOT_W-1:0] in_data_slot,
    input  logic              in_seed_valid,
    output logic              in_seed_ready,
    input  logic              in_key_valid,
    input  logic [SLOT_W-1:0] in_key_slot,
    input  logic              ksu_busy,
    input  logic              core_busy,
    input  logic              prng_busy,
    input  logic              prng_out_valid,
    input  logic              core_in_ready,
    input  logic              ksu_last_key_req,
    output logic              core_valid_in,
    output logic              core_key_schedule_only,
    output logic [SLOT_W-1:0] core_slot,
    output logic              ksu_start_fetch,
    output logic              prng_start_reseed,
    output logic [NSLOT-1:0]  slot_loaded,
    output logic              err_no_key,
    output logic              reseed_required
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LASTKEY,
        RESEED,
        REKEY
    } state_t;

    state_t state;
    logic   busy_seen;
    logic   lastkey_req;
    logic   data_req;
    logic   data_loaded;
    logic   watched_busy;
    logic   op_done;

    // Slots beyond NSLOT (non power-of-two NSLOT) never hold a key.
    function automatic logic slot_ok(input logic [SLOT_W-1:0] s);
        return int'(s) < NSLOT;
    endfunction

    always_comb begin
        lastkey_req            = ksu_last_key_req & prng_out_valid;
        data_req               = in_data_valid & prng_out_valid & ~reseed_required;
        data_loaded            = slot_ok(in_data_slot) && slot_loaded[in_data_slot];
        core_valid_in          = 1'b0;
        core_key_schedule_only = 1'b0;
        in_data_ready          = 1'b0;
        err_no_key             = 1'b0;
        prng_start_reseed      = 1'b0;
        ksu_start_fetch        = 1'b0;
        if (state == IDLE) begin
            if (lastkey_req) begin
                core_valid_in          = 1'b1;
                core_key_schedule_only = 1'b1;
            end else if (data_req) begin
                if (data_loaded) begin
                    core_valid_in = 1'b1;
                    in_data_ready = core_in_ready;
                end else begin
                    in_data_ready = 1'b1;
                    err_no_key    = 1'b1;
                end
            end else if (in_seed_valid) begin
                prng_start_reseed = 1'b1;
            end else if (in_key_valid) begin
                ksu_start_fetch = 1'b1;
            end
        end
    end

    always_comb begin
        watched_busy = 1'b0;
        case (state)
            RUN, LASTKEY: watched_busy = core_busy;
            REKEY:        watched_busy = ksu_busy;
            RESEED:       watched_busy = prng_busy;
            default:      watched_busy = 1'b0;
        endcase
    end

    // An operation ends only after its busy flag has been seen high and then drops.
    assign op_done       = (state != IDLE) && busy_seen && !watched_busy;
    assign in_seed_ready = (state == RESEED) && prng_busy && !busy_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_seen   <= 1'b0;
            core_slot   <= '0;
            slot_loaded <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy_seen <= 1'b0;
                    if (lastkey_req) begin
                        if (core_in_ready) begin
                            state <= LASTKEY;
                        end
                    end else if (data_req) begin
                        if (data_loaded && core_in_ready) begin
                            core_slot <= in_data_slot;
                            state     <= RUN;
                        end
                    end else if (in_seed_valid) begin
                        state <= RESEED;
                    end else if (in_key_valid) begin
                        core_slot <= in_key_slot;
                        state     <= REKEY;
                        if (slot_ok(in_key_slot)) begin
                            slot_loaded[in_key_slot] <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (!busy_seen) begin
                        busy_seen <= watched_busy;
                    end else if (op_done) begin
                        busy_seen <= 1'b0;
                        state     <= IDLE;
                        if (state == REKEY && slot_ok(core_slot)) begin
                            slot_loaded[core_slot] <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef AUTO_RESEED_EN
    logic [CNT_W-1:0] enc_count;
    logic             data_fire;

    assign data_fire       = (state == IDLE) && !lastkey_req && data_req && data_loaded && core_in_ready;
    assign reseed_required = (enc_count == CNT_W'(RESEED_PERIOD));

    // Data is refused once the budget is reached, so the count saturates there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
        end else if (state == RESEED && op_done) begin
            enc_count <= '0;
        end else if (data_fire && !reseed_required) begin
            enc_count <= enc_count + 1'b1;
        end
    end
`else
    assign reseed_required = 1'b0;
`endif

endmodule

// File: tb/tb_aes_op_scheduler.sv
// Self-checking bench for aes_op_scheduler: directed vectors, corner sequences and a randomized model check.
module tb_aes_op_scheduler;

    localparam int NSLOT  = 4;
    localparam int PERIOD = 3;

    logic       clk;
    logic       rst_n;
    logic       in_data_valid, in_data_ready;
    logic [1:0] in_data_slot;
    logic       in_seed_valid, in_seed_ready;
    logic       in_key_valid;
    logic [1:0] in_key_slot;
    logic       ksu_busy, core_busy, prng_busy, prng_out_valid, core_in_ready, ksu_last_key_req;
    logic       core_valid_in, core_key_schedule_only, ksu_start_fetch, prng_start_reseed;
    logic [1:0] core_slot;
    logic [3:0] slot_loaded;
    logic       err_no_key, reseed_required;

    int compared   = 0;
    int mismatched = 0;

    aes_op_scheduler #(
        .NSLOT(NSLOT), .SLOT_W(2), .RESEED_PERIOD(PERIOD), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data_valid(in_data_valid), .in_data_ready(in_data_ready), .in_data_slot(in_data_slot),
        .in_seed_valid(in_seed_valid), .in_seed_ready(in_seed_ready),
        .in_key_valid(in_key_valid), .in_key_slot(in_key_slot),
        .ksu_busy(ksu_busy), .core_busy(core_busy), .prng_busy(prng_busy),
        .prng_out_valid(prng_out_valid), .core_in_ready(core_in_ready),
        .ksu_last_key_req(ksu_last_key_req),
        .core_valid_in(core_valid_in), .core_key_schedule_only(core_key_schedule_only),
        .core_slot(core_slot), .ksu_start_fetch(ksu_start_fetch),
        .prng_start_reseed(prng_start_reseed), .slot_loaded(slot_loaded),
        .err_no_key(err_no_key), .reseed_required(reseed_required)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       dv;
        logic [1:0] dslot;
        logic       sv;
        logic       kv;
        logic [1:0] kslot;
        logic       lk;
        logic       pv;
        logic       cir;
        logic       kb;
        logic       cb;
        logic       pb;
    } stim_t;

    typedef struct {
        stim_t      in;
        logic [5:0] exp;
    } vec_t;

    // Reference model: the operation in progress and what the scheduler owns.
    localparam int OP_NONE = 0, OP_DATA = 1, OP_LASTKEY = 2, OP_RESEED = 3, OP_REKEY = 4;

    typedef struct {
        int       op;
        bit       seen;
        bit [3:0] loaded;
        int       slot;
        int       count;
    } model_t;

    model_t m;

    function automatic model_t reset_model();
        model_t r;
        r.op = OP_NONE; r.seen = 0; r.loaded = '0; r.slot = 0; r.count = 0;
        return r;
    endfunction

    function automatic bit budget_out(model_t s);
`ifdef AUTO_RESEED_EN
        return s.count >= PERIOD;
`else
        return s.count < 0;
`endif
    endfunction

    function automatic logic [13:0] exp_bus(model_t s);
        bit cv = 0, ks = 0, dr = 0, er = 0, rs = 0, kf = 0, sr;
        if (s.op == OP_NONE) begin
            if (ksu_last_key_req && prng_out_valid) begin
                cv = 1; ks = 1;
            end else if (in_data_valid && prng_out_valid && !budget_out(s)) begin
                if (s.loaded[in_data_slot]) begin
                    cv = 1; dr = core_in_ready;
                end else begin
                    dr = 1; er = 1;
                end
            end else if (in_seed_valid) begin
                rs = 1;
            end else if (in_key_valid) begin
                kf = 1;
            end
        end
        sr = (s.op == OP_RESEED) && prng_busy && !s.seen;
        return {cv, ks, 2'(s.slot), kf, rs, s.loaded, er, budget_out(s), dr, sr};
    endfunction

    function automatic model_t next_model(model_t s);
        model_t n = s;
        bit busy;
        if (s.op == OP_NONE) begin
            n.seen = 0;
            if (ksu_last_key_req && prng_out_valid) begin
                if (core_in_ready) n.op = OP_LASTKEY;
            end else if (in_data_valid && prng_out_valid && !budget_out(s)) begin
                if (s.loaded[in_data_slot] && core_in_ready) begin
                    n.op    = OP_DATA;
                    n.slot  = int'(in_data_slot);
                    n.count = (s.count + 1 > PERIOD) ? PERIOD : s.count + 1;
                end
            end else if (in_seed_valid) begin
                n.op = OP_RESEED;
            end else if (in_key_valid) begin
                n.op = OP_REKEY;
                n.slot = int'(in_key_slot);
                n.loaded[in_key_slot] = 1'b0;
            end
        end else begin
            if (s.op == OP_REKEY)       busy = ksu_busy;
            else if (s.op == OP_RESEED) busy = prng_busy;
            else                        busy = core_busy;
            if (!s.seen) begin
                n.seen = busy;
            end else if (!busy) begin
                if (s.op == OP_REKEY)  n.loaded[s.slot] = 1'b1;
                if (s.op == OP_RESEED) n.count = 0;
                n.op   = OP_NONE;
                n.seen = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= reset_model();
        else        m <= next_model(m);
    end

    logic [13:0] dut_bus;
    assign dut_bus = {core_valid_in, core_key_schedule_only, core_slot, ksu_start_fetch, prng_start_reseed,
                      slot_loaded, err_no_key, reseed_required, in_data_ready, in_seed_ready};

    function automatic stim_t mk(bit dv, int dslot, bit sv, bit kv, int kslot, bit lk, bit pv, bit cir);
        stim_t s = '0;
        s.dv = dv; s.dslot = 2'(dslot); s.sv = sv; s.kv = kv; s.kslot = 2'(kslot);
        s.lk = lk; s.pv = pv; s.cir = cir;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        in_data_valid    = s.dv;
        in_data_slot     = s.dslot;
        in_seed_valid    = s.sv;
        in_key_valid     = s.kv;
        in_key_slot      = s.kslot;
        ksu_last_key_req = s.lk;
        prng_out_valid   = s.pv;
        core_in_ready    = s.cir;
        ksu_busy         = s.kb;
        core_busy        = s.cb;
        prng_busy        = s.pb;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        #4;
        checkOutput("model", 16'(dut_bus), 16'(exp_bus(m)));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic runEncrypt(input int slot);
        stim_t s;
        s = mk(1, slot, 0, 0, 0, 0, 1, 1);
        applyStimulus(s); settle();
        checkOutput("enc_start", {core_valid_in, in_data_ready}, 2'b11);
        advance();
        s = '0; s.cb = 1;
        applyStimulus(s); settle(); advance();
        s.cb = 0;
        applyStimulus(s); settle(); advance();
    endtask

    vec_t vecs[13];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        int pulses;

        vecs[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 6'b000000};
        vecs[1]  = '{mk(1, 2, 0, 0, 0, 0, 1, 1), 6'b101000};
        vecs[2]  = '{mk(1, 2, 0, 0, 0, 0, 1, 0), 6'b100000};
        vecs[3]  = '{mk(1, 2, 0, 0, 0, 0, 0, 1), 6'b000000};
        vecs[4]  = '{mk(1, 1, 0, 0, 0, 0, 1, 0), 6'b001100};
        vecs[5]  = '{mk(1, 3, 1, 0, 0, 0, 1, 1), 6'b001100};
        vecs[6]  = '{mk(0, 0, 1, 1, 1, 0, 1, 1), 6'b000010};
        vecs[7]  = '{mk(0, 0, 0, 1, 1, 0, 1, 1), 6'b000001};
        vecs[8]  = '{mk(1, 2, 0, 0, 0, 1, 1, 1), 6'b110000};
        vecs[9]  = '{mk(0, 0, 1, 0, 0, 1, 0, 1), 6'b000010};
        vecs[10] = '{mk(0, 0, 0, 0, 0, 1, 1, 0), 6'b110000};
        vecs[11] = '{mk(1, 2, 0, 1, 3, 0, 0, 1), 6'b000001};
        vecs[12] = '{mk(1, 0, 1, 1, 1, 0, 1, 1), 6'b001100};

        rst_n = 1'b1;
        applyStimulus('0);
        #2 rst_n = 1'b0;
        advance();
        settle();
        checkOutput("reset_outputs", 16'(dut_bus), 16'h0);
        advance();
        rst_n = 1'b1;
        settle();
        checkOutput("post_reset_outputs", 16'(dut_bus), 16'h0);
        advance();

        // Key load into slot 2 with a 5-cycle key holder busy window.
        s = mk(0, 0, 0, 1, 2, 0, 1, 0);
        applyStimulus(s); settle();
        checkOutput("rekey_start", ksu_start_fetch, 1);
        advance();
        s = '0; s.kb = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(s); settle();
            checkOutput("rekey_busy", {core_slot, slot_loaded, ksu_start_fetch}, 7'b10_0000_0);
            advance();
        end
        s.kb = 0;
        applyStimulus(s); settle();
        checkOutput("rekey_last", slot_loaded, 4'b0000);
        advance(); settle();
        checkOutput("rekey_loaded", slot_loaded, 4'b0100);
        advance();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].in);
            #2;
            checkOutput($sformatf("vec%0d", i),
                        {core_valid_in, core_key_schedule_only, in_data_ready, err_no_key,
                         prng_start_reseed, ksu_start_fetch}, 16'(vecs[i].exp));
            applyStimulus('0);
            settle();
            advance();
        end

        // Data into loaded slot 2.
        runEncrypt(2);
        checkOutput("run_slot", core_slot, 2);

        // Seed and key together: reseed first, exactly one seed pulse, then fetch.
        s = mk(0, 0, 1, 1, 3, 0, 1, 0);
        applyStimulus(s); settle();
        checkOutput("seed_first", {prng_start_reseed, ksu_start_fetch}, 2'b10);
        advance();
        pulses = 0;
        s.pb = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(s); settle();
            if (in_seed_ready) pulses++;
            checkOutput("seed_hold", ksu_start_fetch, 0);
            advance();
            s.sv = 0;
        end
        checkOutput("seed_pulses", pulses, 1);
        s.pb = 0;
        applyStimulus(s); settle(); advance();
        applyStimulus(s); settle();
        checkOutput("key_after_seed", ksu_start_fetch, 1);
        advance();
        s = '0; s.kb = 1;
        applyStimulus(s); settle(); advance();
        s.kb = 0;
        applyStimulus(s); settle(); advance();
        settle();
        checkOutput("slot3_loaded", slot_loaded, 4'b1100);
        advance();

        // Last-key request beats pending data, which waits for LASTKEY to finish.
        s = mk(1, 2, 0, 0, 0, 1, 1, 1);
        applyStimulus(s); settle();
        checkOutput("lastkey_first", {core_valid_in, core_key_schedule_only, in_data_ready}, 3'b110);
        advance();
        s.lk = 0; s.cb = 1;
        applyStimulus(s); settle();
        checkOutput("lastkey_hold", {core_valid_in, in_data_ready}, 2'b00);
        advance();
        s.cb = 0;
        applyStimulus(s); settle();
        checkOutput("lastkey_end", {core_valid_in, in_data_ready}, 2'b00);
        advance();
        applyStimulus(s); settle();
        checkOutput("data_after_lastkey", {core_valid_in, core_key_schedule_only, in_data_ready}, 3'b101);
        advance();
        s = '0; s.cb = 1;
        applyStimulus(s); settle(); advance();
        s.cb = 0;
        applyStimulus(s); settle(); advance();

        // Encryption budget: clear count with a reseed, then 3 runs and a 4th.
        s = mk(0, 0, 1, 0, 0, 0, 1, 0);
        applyStimulus(s); settle(); advance();
        s.sv = 0; s.pb = 1;
        applyStimulus(s); settle(); advance();
        s.pb = 0;
        applyStimulus(s); settle(); advance();
        for (int i = 0; i < 3; i++) runEncrypt(2);
        s = mk(1, 2, 1, 0, 0, 0, 1, 1);
        applyStimulus(s); settle();
`ifdef AUTO_RESEED_EN
        checkOutput("budget_stall", {reseed_required, core_valid_in, in_data_ready, prng_start_reseed}, 4'b1001);
        advance();
        s.sv = 0; s.pb = 1;
        applyStimulus(s); settle();
        checkOutput("stall_in_reseed", {core_valid_in, in_data_ready}, 2'b00);
        advance();
        s.pb = 0;
        applyStimulus(s); settle(); advance();
        applyStimulus(s); settle();
        checkOutput("fourth_accepted", {reseed_required, core_valid_in, in_data_ready}, 3'b011);
        advance();
`else
        checkOutput("no_budget", {reseed_required, core_valid_in, in_data_ready, prng_start_reseed}, 4'b0110);
        advance();
`endif
        s = '0; s.cb = 1;
        applyStimulus(s); settle(); advance();
        s.cb = 0;
        applyStimulus(s); settle(); advance();
        checkOutput("count_one", reseed_required, 0);
        runEncrypt(2);
        runEncrypt(2);
        settle();
`ifdef AUTO_RESEED_EN
        checkOutput("count_full", reseed_required, 1);
`else
        checkOutput("count_full", reseed_required, 0);
`endif
        advance();

        // Reset in the middle of a reseed-free data run.
        s = mk(0, 0, 1, 0, 0, 0, 1, 0);
        applyStimulus(s); settle(); advance();
        s.sv = 0; s.pb = 1;
        applyStimulus(s); settle(); advance();
        s.pb = 0;
        applyStimulus(s); settle(); advance();
        s = mk(1, 3, 0, 0, 0, 0, 1, 1);
        applyStimulus(s); settle(); advance();
        s = '0; s.cb = 1;
        applyStimulus(s);
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_mid_run", 16'(dut_bus), 16'h0);
        #2 checkOutput("model", 16'(dut_bus), 16'(exp_bus(m)));
        advance();
        rst_n = 1'b1;
        applyStimulus('0); settle(); advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            s.dv    = ($urandom_range(99) < 50);
            s.dslot = 2'($urandom_range(3));
            s.sv    = ($urandom_range(99) < 12);
            s.kv    = ($urandom_range(99) < 25);
            s.kslot = 2'($urandom_range(3));
            s.lk    = ($urandom_range(99) < 12);
            s.pv    = ($urandom_range(99) < 80);
            s.cir   = ($urandom_range(99) < 70);
            s.kb    = ($urandom_range(99) < 50);
            s.cb    = ($urandom_range(99) < 50);
            s.pb    = ($urandom_range(99) < 50);
            applyStimulus(s);
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
